// File: rtl/oldland_cache_ctrl.sv
// N-way set-associative cache controller: tree PLRU replacement, uncached bypass,
// write-miss forwarding and flush aggregation. `CACHE_STATS_EN adds hit/miss counters.
module oldland_cache_ctrl #(
  parameter int NUM_WAYS   = 4,
  parameter int CACHE_SIZE = 8192,
  parameter int LINE_SIZE  = 32,
  parameter bit READ_ONLY  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     c_access,
  input  logic [29:0]              c_addr,
  input  logic                     c_wr_en,
  input  logic [31:0]              c_wr_val,
  input  logic [3:0]               c_bytesel,
  output logic [31:0]              c_data,
  output logic                     c_ack,
  output logic                     c_error,
  input  logic                     c_flush,
  output logic                     cacheop_complete,
  input  logic                     cacheable_addr,
  input  logic [NUM_WAYS-1:0]      w_hit,
  input  logic [NUM_WAYS-1:0]      w_ack,
  input  logic [NUM_WAYS-1:0]      w_error,
  input  logic [32*NUM_WAYS-1:0]   w_data,
  input  logic [NUM_WAYS-1:0]      w_m_access,
  input  logic [NUM_WAYS-1:0]      w_m_wr_en,
  input  logic [30*NUM_WAYS-1:0]   w_m_addr,
  input  logic [32*NUM_WAYS-1:0]   w_m_wr_val,
  input  logic [4*NUM_WAYS-1:0]    w_m_bytesel,
  input  logic [NUM_WAYS-1:0]      w_cacheop_complete,
  output logic [NUM_WAYS-1:0]      w_fill_sel,
  output logic                     m_access,
  output logic [29:0]              m_addr,
  output logic [31:0]              m_wr_val,
  output logic                     m_wr_en,
  output logic [3:0]               m_bytesel,
  input  logic [31:0]              m_data,
  input  logic                     m_ack,
  input  logic                     m_error
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]              stat_hits,
  output logic [31:0]              stat_misses
`endif
);

  localparam int LINES    = CACHE_SIZE / NUM_WAYS / LINE_SIZE;
  localparam int IDX_BITS = $clog2(LINES);
  localparam int OFF      = $clog2(LINE_SIZE / 4);
  localparam int WAY_BITS = $clog2(NUM_WAYS);
  localparam int NODES    = NUM_WAYS - 1;

  typedef enum logic [2:0] {
    ST_CACHED,
    ST_BYPASS,
    ST_WRITE_MISS,
    ST_FILL,
    ST_FLUSH
  } state_t;

  // Walk the heap-ordered tree from the root; a 0 node sends us to the lower half.
  function automatic logic [WAY_BITS-1:0] plru_victim(input logic [NODES-1:0] bits);
    logic [WAY_BITS-1:0] way;
    int node;
    way  = '0;
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      for (int n = 0; n < NODES; n++)
        if (n == node) way[WAY_BITS-1-l] = bits[n];
      node = 2 * node + 1 + (way[WAY_BITS-1-l] ? 1 : 0);
    end
    return way;
  endfunction

  // Point every node on the accessed way's path away from that way.
  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_BITS-1:0] way);
    logic [NODES-1:0] res;
    logic b;
    int node;
    res  = bits;
    node = 0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b = way[WAY_BITS-1-l];
      for (int n = 0; n < NODES; n++)
        if (n == node) res[n] = ~b;
      node = 2 * node + 1 + (b ? 1 : 0);
    end
    return res;
  endfunction

  state_t                state;
  logic                  lat_access;
  logic                  lat_cacheable;
  logic [29:0]           lat_addr;
  logic                  lat_wr_en;
  logic [31:0]           lat_wr_val;
  logic [3:0]            lat_bytesel;
  logic [IDX_BITS-1:0]   lat_idx;

  logic [NODES-1:0]      plru [LINES];
  logic [WAY_BITS-1:0]   victim;
  logic [NUM_WAYS-1:0]   flush_mask;
  logic                  m_access_q;
  logic                  bypass_ack;
  logic                  bypass_err;
  logic [31:0]           bypass_data;

  logic                  lat_valid;
  logic                  any_hit;
  logic                  single_hit;
  logic                  multi_hit;
  logic                  go_bypass;
  logic                  go_miss;
  logic                  fill_done;
  logic                  upd_en;
  logic [WAY_BITS-1:0]   hit_way;
  logic [WAY_BITS-1:0]   upd_way;
  logic [NODES-1:0]      upd_bits;
  logic [NODES-1:0]      lookup_bits;
  logic [WAY_BITS-1:0]   new_victim;

  assign lat_valid  = lat_access && lat_cacheable;
  assign any_hit    = |w_hit;
  assign single_hit = lat_valid && $onehot(w_hit);
  assign multi_hit  = lat_valid && any_hit && !$onehot(w_hit);
  assign go_bypass  = (state == ST_CACHED) && c_access && !cacheable_addr;
  assign go_miss    = (state == ST_CACHED) && !go_bypass && lat_valid && !any_hit;
  assign fill_done  = (state == ST_FILL) && (|w_ack);
  assign upd_en     = single_hit || fill_done;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    hit_way = '0;
    for (int i = 0; i < NUM_WAYS; i++)
      if (w_hit[i]) hit_way = WAY_BITS'(i);
  end

  // Write-first: a lookup in the same cycle as an update sees the updated tree.
  always_comb begin
    upd_way     = fill_done ? victim : hit_way;
    upd_bits    = plru_touch(plru[lat_idx], upd_way);
    lookup_bits = upd_en ? upd_bits : plru[lat_idx];
    new_victim  = plru_victim(lookup_bits);
  end

  always_comb begin
    c_ack   = bypass_ack | (|w_ack) | multi_hit;
    c_error = 1'b0;
    c_data  = '0;
    if (bypass_ack) begin
      c_error = bypass_err;
      c_data  = bypass_data;
    end else if (multi_hit) begin
      c_error = 1'b1;
    end else begin
      for (int i = 0; i < NUM_WAYS; i++)
        if (w_ack[i]) begin
          c_data  = w_data[i*32 +: 32];
          c_error = w_error[i];
        end
    end
  end

  // Fills talk to memory through the victim way; everything else uses the latched request.
  always_comb begin
    if (state == ST_FILL) begin
      m_access  = w_m_access[victim];
      m_addr    = w_m_addr[int'(victim)*30 +: 30];
      m_wr_val  = w_m_wr_val[int'(victim)*32 +: 32];
      m_wr_en   = w_m_wr_en[victim];
      m_bytesel = w_m_bytesel[int'(victim)*4 +: 4];
    end else begin
      m_access  = m_access_q;
      m_addr    = lat_addr;
      m_wr_val  = lat_wr_val;
      m_wr_en   = lat_wr_en;
      m_bytesel = lat_bytesel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state            <= ST_CACHED;
      lat_access       <= 1'b0;
      lat_cacheable    <= 1'b0;
      lat_addr         <= '0;
      lat_wr_en        <= 1'b0;
      lat_wr_val       <= '0;
      lat_bytesel      <= '0;
      lat_idx          <= '0;
      victim           <= '0;
      w_fill_sel       <= NUM_WAYS'(1);
      flush_mask       <= '0;
      m_access_q       <= 1'b0;
      bypass_ack       <= 1'b0;
      bypass_err       <= 1'b0;
      bypass_data      <= '0;
      cacheop_complete <= 1'b0;
      // NOTE: the PLRU store is flops, not RAM, because replacement order must be deterministic after reset.
      for (int s = 0; s < LINES; s++) plru[s] <= '0;
    end else begin
      lat_access       <= c_access && (state == ST_CACHED);
      bypass_ack       <= 1'b0;
      cacheop_complete <= 1'b0;

      if (c_access && (state == ST_CACHED)) begin
        lat_cacheable <= cacheable_addr;
        lat_addr      <= c_addr;
        lat_wr_en     <= c_wr_en;
        lat_wr_val    <= c_wr_val;
        lat_bytesel   <= c_bytesel;
        lat_idx       <= c_addr[OFF+IDX_BITS-1:OFF];
      end

      if (upd_en) plru[lat_idx] <= upd_bits;

      case (state)
        ST_CACHED: begin
          if (go_bypass) begin
            state      <= ST_BYPASS;
            m_access_q <= 1'b1;
          end else if (go_miss && lat_wr_en) begin
            state      <= ST_WRITE_MISS;
            m_access_q <= 1'b1;
          end else if (go_miss) begin
            state      <= ST_FILL;
            victim     <= new_victim;
            w_fill_sel <= NUM_WAYS'(1) << new_victim;
          end else if (c_flush && !READ_ONLY) begin
            state <= ST_FLUSH;
          end
        end
        ST_BYPASS, ST_WRITE_MISS: begin
          if (m_ack) begin
            m_access_q  <= 1'b0;
            bypass_ack  <= 1'b1;
            bypass_err  <= m_error;
            bypass_data <= (state == ST_BYPASS && !lat_wr_en) ? m_data : 32'd0;
            state       <= ST_CACHED;
          end
        end
        ST_FILL: begin
          if (|w_ack) state <= ST_CACHED;
        end
        ST_FLUSH: begin
          if ((flush_mask | w_cacheop_complete) == {NUM_WAYS{1'b1}}) begin
            cacheop_complete <= 1'b1;
            flush_mask       <= '0;
            state            <= ST_CACHED;
          end else begin
            flush_mask <= flush_mask | w_cacheop_complete;
          end
        end
        default: state <= ST_CACHED;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // Saturating counters: a wrapped count would read as a tiny number.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else begin
      if (single_hit && stat_hits != 32'hFFFF_FFFF) stat_hits <= stat_hits + 32'd1;
      if (go_miss && stat_misses != 32'hFFFF_FFFF) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule
